// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - 640x480@60 timing constants, RGB888 type and colour-bar table
package video_timing_pkg;

    localparam int COORD_W = 10;

    localparam int VT_H_ACTIVE = 640;
    localparam int VT_H_FP     = 16;
    localparam int VT_H_SYNC   = 96;
    localparam int VT_H_BP     = 48;
    localparam int VT_V_ACTIVE = 480;
    localparam int VT_V_FP     = 10;
    localparam int VT_V_SYNC   = 2;
    localparam int VT_V_BP     = 33;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam rgb888_t BAR_COLORS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic rgb888_t bar_color(input logic [COORD_W-1:0] x, input int bar_w);
        int idx;
        idx = int'(x) / bar_w;
        if (idx > 7) idx = 7;
        return BAR_COLORS[idx[2:0]];
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - WIDTH x DEPTH shift register with flush on reset; DEPTH=0 passes through
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_rst;
            assign o_data = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster counters, pixel fetch requests and pixel/sync realignment
// Optional TEST_PATTERN_EN: test_en replaces source pixels with eight vertical colour bars.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VT_H_ACTIVE,
    parameter int   H_FP     = VT_H_FP,
    parameter int   H_SYNC   = VT_H_SYNC,
    parameter int   H_BP     = VT_H_BP,
    parameter int   V_ACTIVE = VT_V_ACTIVE,
    parameter int   V_FP     = VT_V_FP,
    parameter int   V_SYNC   = VT_V_SYNC,
    parameter int   V_BP     = VT_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   LATENCY  = 2
) (
    input  logic               pix_clk,
    input  logic               rst,
    output logic               req,
    output logic [COORD_W-1:0] req_x,
    output logic [COORD_W-1:0] req_y,
    output logic               frame_start,
    input  logic               pix_valid,
    input  logic [23:0]        pix_data,
    input  logic               test_en,
    input  logic               underflow_clr,
    output logic               underflow,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               hsync,
    output logic               vsync,
    output logic               de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] L_H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] L_V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] L_H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] L_V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] L_HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] L_HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] L_VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] L_VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == L_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == L_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    logic w_active;
    assign w_active = (r_h_cnt < L_H_ACT) && (r_v_cnt < L_V_ACT);

    logic               r_req;
    logic [COORD_W-1:0] r_req_x;
    logic [COORD_W-1:0] r_req_y;
    logic               r_frame_start;
    logic               r_hs_raw;
    logic               r_vs_raw;

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_req         <= 1'b0;
            r_req_x       <= '0;
            r_req_y       <= '0;
            r_frame_start <= 1'b0;
            r_hs_raw      <= 1'b0;
            r_vs_raw      <= 1'b0;
        end else begin
            r_req         <= w_active;
            r_req_x       <= w_active ? r_h_cnt : '0;
            r_req_y       <= w_active ? r_v_cnt : '0;
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            r_hs_raw      <= (r_h_cnt >= L_HS_START) && (r_h_cnt < L_HS_END);
            r_vs_raw      <= (r_v_cnt >= L_VS_START) && (r_v_cnt < L_VS_END);
        end
    end

    assign req         = r_req;
    assign req_x       = r_req_x;
    assign req_y       = r_req_y;
    assign frame_start = r_frame_start;

    // Delay the request-stage timing so it lines up with the source's response
    logic [2:0] w_sync_d;
    logic       w_hs_d;
    logic       w_vs_d;
    logic       w_de_d;

    sync_delay_line #(.WIDTH(3), .DEPTH(LATENCY)) u_sync_delay (
        .i_clk  (pix_clk),
        .i_rst  (rst),
        .i_data ({r_hs_raw, r_vs_raw, r_req}),
        .o_data (w_sync_d)
    );

    assign w_hs_d = w_sync_d[2];
    assign w_vs_d = w_sync_d[1];
    assign w_de_d = w_sync_d[0];

    rgb888_t w_rgb_next;
    logic    w_uf_set;

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [COORD_W-1:0] w_x_d;

    sync_delay_line #(.WIDTH(COORD_W), .DEPTH(LATENCY)) u_x_delay (
        .i_clk  (pix_clk),
        .i_rst  (rst),
        .i_data (r_req_x),
        .o_data (w_x_d)
    );

    always_comb begin
        w_rgb_next = '0;
        w_uf_set   = 1'b0;
        if (w_de_d) begin
            if (test_en) begin
                w_rgb_next = bar_color(w_x_d, BAR_W);
            end else if (pix_valid) begin
                w_rgb_next = rgb888_t'(pix_data);
            end else begin
                w_uf_set = 1'b1;
            end
        end
    end
`else
    logic w_unused_test_en;
    assign w_unused_test_en = test_en;

    always_comb begin
        w_rgb_next = '0;
        w_uf_set   = 1'b0;
        if (w_de_d) begin
            if (pix_valid) begin
                w_rgb_next = rgb888_t'(pix_data);
            end else begin
                w_uf_set = 1'b1;
            end
        end
    end
`endif

    logic    r_de;
    logic    r_hsync;
    logic    r_vsync;
    rgb888_t r_rgb;
    logic    r_underflow;

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_de        <= 1'b0;
            r_hsync     <= ~SYNC_POL;
            r_vsync     <= ~SYNC_POL;
            r_rgb       <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_de        <= w_de_d;
            r_hsync     <= w_hs_d ? SYNC_POL : ~SYNC_POL;
            r_vsync     <= w_vs_d ? SYNC_POL : ~SYNC_POL;
            r_rgb       <= w_rgb_next;
            // A fresh underflow beats a simultaneous clear
            r_underflow <= w_uf_set | (r_underflow & ~underflow_clr);
        end
    end

    assign de        = r_de;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign red       = r_rgb.r;
    assign green     = r_rgb.g;
    assign blue      = r_rgb.b;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - cycle model check of video_timing_ctrl with directed source stimulus
module tb_video_timing_ctrl;

    // Full-width lines, shortened vertical raster so a whole frame plus a reset restart stays short
    localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_ACTIVE = 52,  V_FP = 2,  V_SYNC = 2,  V_BP = 2;
    localparam int LAT      = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int RST_AT   = FRAME + 5 * H_TOTAL + 300;

    localparam logic [23:0] BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

`ifdef TEST_PATTERN_EN
    localparam bit          TP_BUILD = 1'b1;
    localparam logic [23:0] TP_X0    = 24'hFFFFFF;
    localparam logic [23:0] TP_X80   = 24'hFFFF00;
    localparam logic        TP_UF    = 1'b0;
`else
    localparam bit          TP_BUILD = 1'b0;
    localparam logic [23:0] TP_X0    = 24'h000000;
    localparam logic [23:0] TP_X80   = 24'h000000;
    localparam logic        TP_UF    = 1'b1;
`endif

    logic        pix_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req;
    logic [9:0]  req_x, req_y;
    logic        frame_start;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic        test_en = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        underflow;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, de;

    video_timing_ctrl #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(1'b0), .LATENCY(LAT)
    ) dut (
        .pix_clk(pix_clk), .rst(rst),
        .req(req), .req_x(req_x), .req_y(req_y), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data), .test_en(test_en),
        .underflow_clr(underflow_clr), .underflow(underflow),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de)
    );

    always #20 pix_clk = ~pix_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int hpos(int k); return (k % FRAME) % H_TOTAL; endfunction
    function automatic int vpos(int k); return (k % FRAME) / H_TOTAL; endfunction
    function automatic bit is_active(int k); return hpos(k) < H_ACTIVE && vpos(k) < V_ACTIVE; endfunction
    function automatic bit is_hs(int k);
        return hpos(k) >= H_ACTIVE + H_FP && hpos(k) < H_ACTIVE + H_FP + H_SYNC;
    endfunction
    function automatic bit is_vs(int k);
        return vpos(k) >= V_ACTIVE + V_FP && vpos(k) < V_ACTIVE + V_FP + V_SYNC;
    endfunction
    function automatic int idx(int x, int y); return y * H_TOTAL + x; endfunction
    function automatic logic [23:0] pix_fn(int k);
        logic [9:0] hh, vv;
        hh = 10'(hpos(k));
        vv = 10'(vpos(k));
        return {hh, vv, 4'hA};
    endfunction

    int          t_rel = 0;
    int          phase = 1;
    bit          prev_rst = 1'b1;
    bit          prev_pv = 1'b0;
    logic [23:0] prev_pd = '0;
    bit          prev_clr = 1'b0;
    bit          prev_te = 1'b0;
    bit          exp_uf = 1'b0;
    int          de_count = 0;
    int          hs_low = 0;

    initial begin
        int          ko, k;
        bit          exp_req, exp_de, tp, act;
        int          exp_x, exp_y;
        bit          exp_fs;
        logic        exp_hs, exp_vs;
        logic [23:0] exp_rgb;

        for (int cyc = 0; cyc < 60000; cyc++) begin
            @(posedge pix_clk);
            #1;
            t_rel = prev_rst ? 0 : t_rel + 1;

            exp_req = (t_rel >= 1) && is_active(t_rel - 1);
            exp_x   = exp_req ? hpos(t_rel - 1) : 0;
            exp_y   = exp_req ? vpos(t_rel - 1) : 0;
            exp_fs  = (t_rel >= 1) && ((t_rel - 1) % FRAME == 0);
            ko      = t_rel - LAT - 2;
            exp_de  = (ko >= 0) && is_active(ko);
            exp_hs  = (ko >= 0 && is_hs(ko)) ? 1'b0 : 1'b1;
            exp_vs  = (ko >= 0 && is_vs(ko)) ? 1'b0 : 1'b1;
            tp      = TP_BUILD && prev_te;
            if (!exp_de)     exp_rgb = 24'h0;
            else if (tp)     exp_rgb = BARS[hpos(ko) / (H_ACTIVE / 8)];
            else if (prev_pv) exp_rgb = prev_pd;
            else             exp_rgb = 24'h0;
            if (prev_rst) exp_uf = 1'b0;
            else          exp_uf = (exp_de && !tp && !prev_pv) || (exp_uf && !prev_clr);

            check("req", req, exp_req);
            check("req_x", req_x, exp_x);
            check("req_y", req_y, exp_y);
            check("frame_start", frame_start, exp_fs);
            check("de", de, exp_de);
            check("hsync", hsync, exp_hs);
            check("vsync", vsync, exp_vs);
            check("rgb", {red, green, blue}, exp_rgb);
            check("underflow", underflow, exp_uf);

            if (phase == 1) begin
                if (t_rel < FRAME && de) de_count++;
                if (t_rel >= 4 && t_rel < 804 && !hsync) hs_low++;
                case (t_rel)
                    0: begin
                        check("rst_req", req, 0);
                        check("rst_de", de, 0);
                        check("rst_hsync", hsync, 1);
                        check("rst_vsync", vsync, 1);
                        check("rst_underflow", underflow, 0);
                    end
                    1: begin
                        check("first_req", req, 1);
                        check("first_frame_start", frame_start, 1);
                    end
                    2: check("frame_start_pulse", frame_start, 0);
                    3: check("de_before_latency", de, 0);
                    4: begin
                        check("de_first", de, 1);
                        check("rgb_first", {red, green, blue}, 24'h00000A);
                    end
                    643: check("de_last_pixel", de, 1);
                    644: check("de_line_end", de, 0);
                    659: check("hsync_before", hsync, 1);
                    660: check("hsync_fall", hsync, 0);
                    755: check("hsync_last", hsync, 0);
                    756: check("hsync_rise", hsync, 1);
                    804: check("hsync_low_width", hs_low, 96);
                    40103: check("uf_before_drop", underflow, 0);
                    40104: begin
                        check("uf_drop_set", underflow, 1);
                        check("rgb_drop_black", {red, green, blue}, 24'h0);
                    end
                    40105: check("rgb_after_drop", {red, green, blue}, 24'h19432A);
                    40153: check("uf_held", underflow, 1);
                    40154: check("uf_cleared", underflow, 0);
                    41003: check("uf_before_2nd", underflow, 0);
                    41004: check("uf_clr_collision", underflow, 1);
                    41104: check("uf_cleared_2nd", underflow, 0);
                    43203: check("vsync_before", vsync, 1);
                    43204: check("vsync_fall", vsync, 0);
                    44803: check("vsync_last", vsync, 0);
                    44804: check("vsync_rise", vsync, 1);
                    FRAME: check("de_per_frame", de_count, H_ACTIVE * V_ACTIVE);
                    FRAME + 1: check("frame2_start", frame_start, 1);
                    default: ;
                endcase
            end else begin
                case (t_rel)
                    0: begin
                        check("midrst_de", de, 0);
                        check("midrst_req", req, 0);
                        check("midrst_hsync", hsync, 1);
                    end
                    1: check("restart_frame_start", frame_start, 1);
                    4:   check("tp_x0", {red, green, blue}, TP_X0);
                    83:  check("tp_x79", {red, green, blue}, TP_X0);
                    84:  check("tp_x80", {red, green, blue}, TP_X80);
                    643: check("tp_x639", {red, green, blue}, 24'h000000);
                    644: check("tp_underflow", underflow, TP_UF);
                    default: ;
                endcase
                if (t_rel == 700) break;
            end

            k   = t_rel - LAT - 1;
            act = (k >= 0) && is_active(k);
            prev_rst = (cyc < 3) || (phase == 1 && t_rel == RST_AT);
            if (phase == 1 && t_rel == RST_AT) phase = 2;
            rst           = prev_rst;
            test_en       = (phase == 2);
            underflow_clr = (phase == 1) &&
                            (k == idx(150, 50) || k == idx(200, 51) || k == idx(300, 51));
            if (act) begin
                pix_valid = (phase == 1) && k != idx(100, 50) && k != idx(200, 51);
                pix_data  = pix_fn(k);
            end else begin
                pix_valid = 1'b1;
                pix_data  = 24'hABCDEF;
            end
            prev_pv  = pix_valid;
            prev_pd  = pix_data;
            prev_clr = underflow_clr;
            prev_te  = test_en;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
Sequencer for the TMDS transmitter datapath. Generates 640x480@60 raster timing on the 25 MHz pixel clock and issues per-pixel fetch requests to an upstream pixel source. Re-aligns the returned pixels with delayed hsync/vsync/de so that red/green/blue/hsync/vsync/de drive the transmitter inputs directly. Flags source underflow.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted sync level (0 = negative sync)
LATENCY, 2, source cycles from req to pix_valid/pix_data (0..15)

Ports:
pix_clk  in  1  pixel clock, sole clock
rst  in  1  synchronous active-high reset
req  out  1  pixel fetch request, active pixel of request stage
req_x  out  10  request column, 0..H_ACTIVE-1
req_y  out  10  request row, 0..V_ACTIVE-1
frame_start  out  1  one-cycle pulse with req at (0,0)
pix_valid  in  1  source data valid, LATENCY cycles after req
pix_data  in  24  {red,green,blue} from source
test_en  in  1  test pattern select (used only with TEST_PATTERN_EN)
underflow_clr  in  1  clears underflow flag
underflow  out  1  sticky: active pixel arrived without pix_valid
red/green/blue  out  8 each  to transmitter
hsync, vsync, de  out  1 each  to transmitter

Behaviour:
- Both clocks and reset are as decided: one clock, pix_clk; reset rst synchronous, active-high.
- H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- h_cnt 0..H_TOTAL-1 increments every cycle and wraps to 0.
- v_cnt increments when h_cnt wraps; it wraps to 0 after V_TOTAL-1.
- Request stage (registered, one cycle after counter state):
  - req = (h<H_ACTIVE && v<V_ACTIVE); req_x/req_y = h/v; req_x/req_y are 0 when req=0.
  - frame_start = (h==0 && v==0).
  - hs_raw is true for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs_raw uses the same rule on v.
  - Sync output level = SYNC_POL when true, else ~SYNC_POL.
- The {hs, vs, req} triplet passes through a LATENCY-deep delay line, giving de_d, hs_d, vs_d aligned with pix_valid.
- Output stage (registered): de=de_d, hsync=hs_d, vsync=vs_d.
  - RGB = pix_data when de_d && pix_valid, else 0.
- Total latency is req rising to de rising = LATENCY+1 cycles. hsync/vsync keep the same offset relative to de as at the counters.
- pix_valid while de_d=0 is ignored, with no flag.
- Underflow: de_d=1 && pix_valid=0 sets underflow and outputs black for that pixel. Raster timing is unaffected; there is no stall.
- underflow_clr clears underflow; a new underflow in the same cycle wins (flag stays 1).
- Reset values: counters 0, delay line flushed, req=0, frame_start=0, de=0, rgb=0, underflow=0, hsync=vsync=~SYNC_POL.
- First cycle after rst deasserts: counters=(0,0). Next cycle: req=1, frame_start=1.
- Reset mid-frame aborts immediately; the next frame restarts at (0,0).

Optional Feature:
TEST_PATTERN_EN.
- Defined: when test_en=1, RGB during de_d is 8 vertical colour bars selected by the delayed x. Bar width is H_ACTIVE/8 = 80. Order: white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00). pix_valid is ignored and underflow is not set. req and frame_start still toggle.
- Undefined: test_en has no effect; no x delay pipeline is built.

Decomposition:
- Package video_timing_pkg holds:
  - the 640x480 timing constants;
  - COORD_W=10;
  - an RGB888 struct/typedef;
  - the colour-bar constant array.
- One sub-module, sync_delay_line: a parametric WIDTH x DEPTH shift register. DEPTH=0 is a pass-through. It is reused for the {hs,vs,de} delay and the x delay.

Test Plan:
- Reset release, LATENCY=2 -> req/frame_start=1 on cycle 1, de=1 on cycle 4, first pixel = pix_data sampled on cycle 3.
- Full frame with an always-valid source -> 800 cycles/line, 525 lines, 307200 de cycles. hsync low 96 cycles starting 656 cycles after de rises. vsync low for lines 490-491.
- Drop pix_valid for one active pixel at (100,50) -> rgb=0 at that pixel, underflow=1 and held. underflow_clr -> 0 next cycle.
- underflow_clr asserted in the same cycle as a new underflow -> underflow stays 1.
- rst pulsed at (h=300, v=200) -> outputs take reset values the next cycle; frame restarts with frame_start.
- TEST_PATTERN_EN, test_en=1, pix_valid=0 -> x=0..79 gives FFFFFF, x=80 gives FFFF00, x=560..639 gives 000000, underflow=0.
